// File: rtl/mcu_pkg.sv
// mcu_pkg: shared target IDs, router state encoding and reply constants for the MCU command path
package mcu_pkg;

    localparam int TGT_SYSCTRL = 0;
    localparam int TGT_HID     = 1;
    localparam int TGT_SDC     = 2;
    localparam int TGT_SPARE   = 3;

    localparam logic [7:0] REPLY_INVALID = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_FWD,
        ST_DROP
    } router_state_e;

endpackage

// File: rtl/mcu_cmd_router_if.sv
// mcu_cmd_router_if: MCU byte link, slave command bus and interrupt lines around the router
interface mcu_cmd_router_if #(
    parameter int NUM_TARGETS = 4
);
    logic                       mcu_strobe;
    logic                       mcu_start;
    logic [7:0]                 mcu_din;
    logic [7:0]                 mcu_dout;
    logic [NUM_TARGETS-1:0]     tgt_strobe;
    logic [NUM_TARGETS-1:0]     tgt_start;
    logic [7:0]                 tgt_din;
    logic [8*NUM_TARGETS-1:0]   tgt_dout;
    logic [7:0]                 irq_event;
    logic [7:0]                 int_pending;
    logic [7:0]                 int_ack;

    modport master (
        output mcu_strobe, mcu_start, mcu_din, tgt_dout, irq_event, int_ack,
        input  mcu_dout, tgt_strobe, tgt_start, tgt_din, int_pending
    );

    modport slave (
        input  mcu_strobe, mcu_start, mcu_din, tgt_dout, irq_event, int_ack,
        output mcu_dout, tgt_strobe, tgt_start, tgt_din, int_pending
    );

endinterface

// File: rtl/irq_pending_reg.sv
// irq_pending_reg: per-bit sticky interrupt pending register, a set pulse beats a same-cycle clear
module irq_pending_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] set,
    input  logic [W-1:0] clr,
    output logic [W-1:0] pending
);

    logic [W-1:0] pending_d, pending_q;

    // clear acknowledged bits first, then OR in new events so a set always survives
    always_comb pending_d = (pending_q & ~clr) | set;

    // pending bits register
    always_ff @(posedge clk) pending_q <= reset ? '0 : pending_d;

    assign pending = pending_q;

endmodule

// File: rtl/mcu_cmd_router.sv
// mcu_cmd_router: strips the target-ID byte of each MCU frame and streams the rest to the chosen slave
module mcu_cmd_router
    import mcu_pkg::*;
#(
    parameter int          NUM_TARGETS = 4,
    parameter logic [19:0] TIMEOUT     = 20'd1000000
) (
    input logic             clk,
    input logic             reset,
    mcu_cmd_router_if.slave bus
);

    localparam int SW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;

    router_state_e          state_d, state_q;
    logic [SW-1:0]          sel_d, sel_q;
    logic [19:0]            cnt_d, cnt_q;
    logic [7:0]             dout_d, dout_q;
    logic [NUM_TARGETS-1:0] tgt_strobe_d, tgt_strobe_q;
    logic [NUM_TARGETS-1:0] tgt_start_d, tgt_start_q;
    logic [7:0]             tgt_din_d, tgt_din_q;

    logic                   id_ok;
    logic                   active;
    logic                   expired;
    logic [NUM_TARGETS-1:0] one_hot;
    logic [7:0]             reply;

    assign id_ok   = bus.mcu_din < 8'(NUM_TARGETS);
    assign active  = state_q == ST_HDR || state_q == ST_FWD;
    assign expired = cnt_q == TIMEOUT - 20'd1;
    assign one_hot = NUM_TARGETS'(1) << sel_q;
    assign reply   = bus.tgt_dout[{sel_q, 3'b000} +: 8];

    // frame decode: a start byte always re-targets, payload goes only to a live target,
    // and an idle stretch inside a live frame eventually abandons it
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = '0;
        dout_d       = dout_q;
        tgt_strobe_d = '0;
        tgt_start_d  = '0;
        tgt_din_d    = tgt_din_q;
        if (bus.mcu_strobe && bus.mcu_start) begin
            sel_d   = bus.mcu_din[SW-1:0];
            state_d = id_ok ? ST_HDR : ST_DROP;
            dout_d  = id_ok ? 8'(NUM_TARGETS) : REPLY_INVALID;
        end else if (bus.mcu_strobe) begin
            dout_d = active ? reply : REPLY_INVALID;
            if (active) begin
                tgt_strobe_d = one_hot;
                tgt_start_d  = state_q == ST_HDR ? one_hot : '0;
                tgt_din_d    = bus.mcu_din;
                state_d      = ST_FWD;
            end
        end else if (active) begin
            state_d = expired ? ST_IDLE : state_q;
            cnt_d   = expired ? '0 : cnt_q + 20'd1;
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            dout_q       <= 8'h00;
            tgt_strobe_q <= '0;
            tgt_start_q  <= '0;
            tgt_din_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            tgt_strobe_q <= tgt_strobe_d;
            tgt_start_q  <= tgt_start_d;
            tgt_din_q    <= tgt_din_d;
        end
    end

    assign bus.mcu_dout   = dout_q;
    assign bus.tgt_strobe = tgt_strobe_q;
    assign bus.tgt_start  = tgt_start_q;
    assign bus.tgt_din    = tgt_din_q;

    irq_pending_reg #(.W(8)) u_irq (
        .clk     (clk),
        .reset   (reset),
        .set     (bus.irq_event),
        .clr     (bus.int_ack),
        .pending (bus.int_pending)
    );

endmodule

// File: tb/tb_mcu_cmd_router.sv
// tb_mcu_cmd_router: random and directed frames checked against a frame-level model of the router
module tb_mcu_cmd_router;

    localparam int          NT  = 4;
    localparam int          TMO = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    mcu_cmd_router_if #(.NUM_TARGETS(NT)) bus ();

    mcu_cmd_router #(.NUM_TARGETS(NT), .TIMEOUT(20'(TMO))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] slave_f(int k, logic [7:0] d, logic st);
        return (d + 8'(k * 16) + 8'd1) ^ (st ? 8'h80 : 8'h00);
    endfunction

    // slave models: data_out updates on their own forwarded strobe
    logic [7:0] slv [NT] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    always @(posedge clk)
        for (int k = 0; k < NT; k++)
            if (bus.tgt_strobe[k]) slv[k] <= slave_f(k, bus.tgt_din, bus.tgt_start[k]);
    always_comb
        for (int k = 0; k < NT; k++) bus.tgt_dout[8*k +: 8] = slv[k];

    // frame-level reference model
    int         cur = -1;
    bit         started = 1'b0;
    int         idle = 0;
    logic [7:0] msl [NT] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    bit         pv = 1'b0;
    int         pk = 0;
    logic [7:0] pd = 8'h00;
    bit         pst = 1'b0;
    logic [7:0] exp_dout = 8'h00, exp_din = 8'h00, exp_pend = 8'h00;
    logic [NT-1:0] exp_stb = '0, exp_start = '0;

    always @(posedge clk) begin
        logic [7:0] np;
        if (pv) msl[pk] <= slave_f(pk, pd, pst);
        pv        <= 1'b0;
        exp_stb   <= '0;
        exp_start <= '0;
        for (int b = 0; b < 8; b++)
            np[b] = bus.irq_event[b] ? 1'b1 : (bus.int_ack[b] ? 1'b0 : exp_pend[b]);
        if (reset) begin
            cur      <= -1;
            started  <= 1'b0;
            idle     <= 0;
            exp_dout <= 8'h00;
            exp_din  <= 8'h00;
            exp_pend <= 8'h00;
        end else begin
            exp_pend <= np;
            if (bus.mcu_strobe && bus.mcu_start) begin
                idle     <= 0;
                started  <= 1'b0;
                cur      <= int'(bus.mcu_din) < NT ? int'(bus.mcu_din) : -1;
                exp_dout <= int'(bus.mcu_din) < NT ? 8'(NT) : 8'hFF;
            end else if (bus.mcu_strobe) begin
                idle <= 0;
                if (cur >= 0) begin
                    exp_dout  <= msl[cur];
                    exp_stb   <= NT'(1 << cur);
                    exp_start <= started ? '0 : NT'(1 << cur);
                    exp_din   <= bus.mcu_din;
                    started   <= 1'b1;
                    pv        <= 1'b1;
                    pk        <= cur;
                    pd        <= bus.mcu_din;
                    pst       <= !started;
                end else begin
                    exp_dout <= 8'hFF;
                end
            end else if (cur >= 0) begin
                idle <= idle + 1;
                if (idle + 1 >= TMO) cur <= -1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk)
        if (chk_en) begin
            check("mcu_dout", 32'(bus.mcu_dout), 32'(exp_dout));
            check("tgt_strobe", 32'(bus.tgt_strobe), 32'(exp_stb));
            check("tgt_start", 32'(bus.tgt_start), 32'(exp_start));
            check("int_pending", 32'(bus.int_pending), 32'(exp_pend));
            if (exp_stb != '0) check("tgt_din", 32'(bus.tgt_din), 32'(exp_din));
        end

    task automatic cyc(input logic s, input logic st, input logic [7:0] d,
                       input logic [7:0] ev, input logic [7:0] ack, input logic r);
        bus.mcu_strobe = s;
        bus.mcu_start  = st;
        bus.mcu_din    = d;
        bus.irq_event  = ev;
        bus.int_ack    = ack;
        reset          = r;
        @(negedge clk);
    endtask

    task automatic send(input logic st, input logic [7:0] d);
        cyc(1'b1, st, d, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic idle_cy();
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        int r;
        logic [7:0] d, ev, ack;
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        check("rst_dout", 32'(bus.mcu_dout), 32'h00);
        check("rst_strobe", 32'(bus.tgt_strobe), 32'h0);
        check("rst_din", 32'(bus.tgt_din), 32'h00);
        check("rst_pend", 32'(bus.int_pending), 32'h00);

        // sysctrl frame 00,00,11,22
        send(1'b1, 8'h00);
        check("hdr_reply", 32'(bus.mcu_dout), 32'h04);
        check("hdr_no_strobe", 32'(bus.tgt_strobe), 32'h0);
        idle_cy();
        send(1'b0, 8'h00);
        check("cmd_strobe", 32'(bus.tgt_strobe), 32'h1);
        check("cmd_start", 32'(bus.tgt_start), 32'h1);
        check("cmd_reply", 32'(bus.mcu_dout), 32'hA0);
        idle_cy();
        send(1'b0, 8'h11);
        check("pl1_start", 32'(bus.tgt_start), 32'h0);
        check("pl1_reply", 32'(bus.mcu_dout), 32'h81);
        idle_cy();
        send(1'b0, 8'h22);
        check("pl2_reply", 32'(bus.mcu_dout), 32'h12);

        // invalid target frame
        send(1'b1, 8'h07);
        check("bad_hdr", 32'(bus.mcu_dout), 32'hFF);
        send(1'b0, 8'h01);
        check("bad_b1", 32'(bus.mcu_dout), 32'hFF);
        send(1'b0, 8'h02);
        check("bad_strobe", 32'(bus.tgt_strobe), 32'h0);

        // stall past the timeout
        send(1'b1, 8'h01);
        send(1'b0, 8'h04);
        check("hid_reply", 32'(bus.mcu_dout), 32'hA1);
        repeat (TMO) idle_cy();
        send(1'b0, 8'h55);
        check("tmo_reply", 32'(bus.mcu_dout), 32'hFF);
        check("tmo_strobe", 32'(bus.tgt_strobe), 32'h0);

        // re-target mid-frame
        send(1'b1, 8'h01);
        send(1'b0, 8'h10);
        send(1'b0, 8'h11);
        check("fwd1_strobe", 32'(bus.tgt_strobe), 32'h2);
        send(1'b1, 8'h02);
        send(1'b0, 8'h33);
        check("sdc_strobe", 32'(bus.tgt_strobe), 32'h4);
        check("sdc_start", 32'(bus.tgt_start), 32'h4);
        check("sdc_reply", 32'(bus.mcu_dout), 32'hA2);

        // interrupt set/clear priority
        cyc(1'b0, 1'b0, 8'h00, 8'h05, 8'h00, 1'b0);
        check("irq_set", 32'(bus.int_pending), 32'h05);
        cyc(1'b0, 1'b0, 8'h00, 8'h04, 8'h04, 1'b0);
        check("irq_setwins", 32'(bus.int_pending), 32'h05);
        cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h05, 1'b0);
        check("irq_clear", 32'(bus.int_pending), 32'h00);

        // reset during a back-to-back burst
        cyc(1'b0, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0);
        send(1'b1, 8'h00);
        send(1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02, 8'h00, 8'h00, 1'b1);
        check("rstb_dout", 32'(bus.mcu_dout), 32'h00);
        check("rstb_strobe", 32'(bus.tgt_strobe), 32'h0);
        check("rstb_start", 32'(bus.tgt_start), 32'h0);
        check("rstb_din", 32'(bus.tgt_din), 32'h00);
        check("rstb_pend", 32'(bus.int_pending), 32'h00);
        idle_cy();
        check("rstb_after", 32'(bus.tgt_strobe), 32'h0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r   = int'($urandom_range(0, 99));
            ev  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if (r < 1) begin
                cyc(1'b0, 1'b0, 8'h00, ev, ack, 1'b1);
            end else if (r < 4) begin
                repeat (TMO + int'($urandom_range(0, 4))) idle_cy();
            end else if (r < 20) begin
                d = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, NT - 1)) : 8'($urandom_range(NT, 255));
                cyc(1'b1, 1'b1, d, ev, ack, 1'b0);
            end else if (r < 65) begin
                cyc(1'b1, 1'b0, 8'($urandom), ev, ack, 1'b0);
            end else begin
                cyc(1'b0, 1'b0, 8'h00, ev, ack, 1'b0);
            end
        end
        idle_cy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
